// File: rtl/freq_meter.sv
// freq_meter: gated frequency meter.
// Counts rising edges of the asynchronous input sig_in over a window of
// GATE_CYCLES clk cycles and publishes the saturated count on freq, together
// with a one-cycle freq_valid strobe and an overflow flag for that window.
// Back-to-back windows run with no dead time while en stays high.

module freq_meter #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int GATE_CYCLES = 50_000_000,
  parameter int CNT_W       = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq,
  output logic             freq_valid,
  output logic             overflow,
  output logic             busy
);

  // Gate counter only has to reach GATE_CYCLES-1.
  localparam int                GATE_W    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  // Elaboration-time parameter sanity checks; no hardware is generated.
  generate
    if (GATE_CYCLES < 2) begin : g_bad_gate
      $error("freq_meter: GATE_CYCLES must be at least 2");
    end
    if (CLK_HZ < 1) begin : g_bad_clk
      $error("freq_meter: CLK_HZ must be positive");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
      $error("freq_meter: CNT_W must be positive");
    end
  endgenerate

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_MEASURE = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Input path: two-flop synchronizer plus previous-value flop.
  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic w_edge;

  // Window counters.
  logic [GATE_W-1:0] r_gate_cnt;
  logic [CNT_W-1:0]  r_edge_cnt;
  logic              r_sat;       // an edge arrived while r_edge_cnt was already at max

  // Control and result terms.
  logic              w_measure;
  logic              w_last;
  logic              w_clear;
  logic              w_at_max;
  logic [CNT_W-1:0]  w_result;
  logic              w_result_ovf;

  // Published result registers.
  logic [CNT_W-1:0]  r_freq;
  logic              r_freq_valid;
  logic              r_overflow;

  // Synchronize sig_in; all three flops reset high so a signal that is
  // already high when reset releases does not look like a rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= sig_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_edge = r_sync2 & ~r_prev;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: en starts a window, dropping en ends or aborts it.
  // A window that completes with en still high rolls straight into the next.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (en) begin
          w_state_next = S_MEASURE;
        end
      end
      S_MEASURE: begin
        if (!en) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State-derived outputs and window-control decodes.
  always_comb begin
    w_measure = (r_state == S_MEASURE);
    w_last    = w_measure && (r_gate_cnt == GATE_LAST);
    // Counters restart when idle, at the end of a window, or on abort.
    w_clear   = !w_measure || w_last || !en;
    busy      = w_measure;
  end

  // Result of the window: the edge in the last cycle still belongs to it.
  always_comb begin
    w_at_max     = (r_edge_cnt == CNT_MAX);
    w_result     = r_edge_cnt;
    if (w_edge && !w_at_max) begin
      w_result = r_edge_cnt + CNT_W'(1);
    end
    w_result_ovf = r_sat | (w_edge & w_at_max);
  end

  // Gate and edge counters; the edge counter saturates instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gate_cnt <= '0;
      r_edge_cnt <= '0;
      r_sat      <= 1'b0;
    end else if (w_clear) begin
      r_gate_cnt <= '0;
      r_edge_cnt <= '0;
      r_sat      <= 1'b0;
    end else begin
      r_gate_cnt <= r_gate_cnt + GATE_W'(1);
      if (w_edge) begin
        if (w_at_max) begin
          r_sat <= 1'b1;
        end else begin
          r_edge_cnt <= r_edge_cnt + CNT_W'(1);
        end
      end
    end
  end

  // Publish freq/overflow with a one-cycle valid strobe on the last window cycle;
  // an aborted window leaves the previous result untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_freq       <= '0;
      r_freq_valid <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_freq_valid <= w_last;
      if (w_last) begin
        r_freq     <= w_result;
        r_overflow <= w_result_ovf;
      end
    end
  end

  assign freq       = r_freq;
  assign freq_valid = r_freq_valid;
  assign overflow   = r_overflow;

endmodule

// File: doc/freq_meter.md
# freq_meter

Gated frequency meter: counts rising edges of an asynchronous input `sig_in` over a fixed window of `GATE_CYCLES` system-clock cycles and publishes the count as a frequency word. With the defaults (50 MHz clock, 1 s gate), the result is directly in Hz. It is the measuring end of the clock-divider outputs in the design: it consumes a divided clock such as the 10 kHz tick and reports its rate for self-check and display logic.

## Interface
- `CLK_HZ`, 50_000_000, system clock frequency. Documentation and assertions only; no logic uses it.
- `GATE_CYCLES`, 50_000_000, gate window length in `clk` cycles. Must be ≥ 2.
- `CNT_W`, 27, width of the edge counter and the result.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  measurement enable; synchronous level.
- `sig_in`  in  1  signal under measurement; asynchronous to `clk`.
- `freq`  out  CNT_W  last completed window's edge count, saturated.
- `freq_valid`  out  1  one-cycle pulse when `freq` updates.
- `overflow`  out  1  set with each result: 1 if that window's count saturated.
- `busy`  out  1  high while a window is in progress (state MEASURE).

## Operation
- Input path:
  - Two-flop synchronizer on `sig_in`, followed by a previous-value flop.
  - `edge` = synced & ~prev.
  - All three flops reset to 1, so a `sig_in` that is high at reset release never produces a spurious edge.
- States:
  - IDLE: counters held at 0; `busy` = 0. If `en` = 1, go to MEASURE with gate_cnt = 0 and edge_cnt = 0.
  - MEASURE: gate_cnt increments every cycle. edge_cnt increments on `edge` and saturates at 2^CNT_W−1.
- Last window cycle (gate_cnt = GATE_CYCLES−1):
  - `freq` ← sat(edge_cnt + edge).
  - `overflow` ← 1 if the true count exceeds 2^CNT_W−1.
  - `freq_valid` ← 1 for one cycle.
  - gate_cnt and edge_cnt ← 0.
  - If `en` = 1, stay in MEASURE: the next window starts on the next cycle with no dead time, so no edge is lost or double-counted across the boundary. If `en` = 0, go to IDLE.
- `en` falling mid-window (any cycle except the last): abort to IDLE on the next edge. No `freq_valid`; `freq` and `overflow` hold their previous values.
- Counting rules:
  - Edges are counted only in MEASURE cycles; edges seen in IDLE are discarded.
  - Correct counting requires `sig_in` to be high ≥ 2 `clk` cycles and low ≥ 2 `clk` cycles. Faster inputs under-count; this is not flagged.
- Arithmetic:
  - gate_cnt width = clog2(GATE_CYCLES).
  - edge_cnt never wraps.
  - The result is unsigned.

## Timing
- Reset values: `freq` = 0, `freq_valid` = 0, `overflow` = 0, `busy` = 0, state = IDLE, all counters 0.
- `sig_in` rise to `edge` pulse: 2–3 `clk` cycles (synchronizer latency plus sampling uncertainty).
- `en` sampled high in cycle N: `busy` = 1 from N+1; the window covers cycles N+1 … N+GATE_CYCLES.
- `freq`, `overflow` and `freq_valid` all update in the same cycle, N+GATE_CYCLES+1. They repeat every GATE_CYCLES cycles while `en` stays high.
- Reset asserted mid-window: immediate return to reset values. No partial result is published.
- `en` deasserted exactly on the last window cycle: the result is published, then the block enters IDLE.

## Test plan
All scenarios use GATE_CYCLES = 100, CNT_W = 8 unless stated.
- Basic count: `sig_in` toggles every 5 clk (period 10), `en` held high → every 100 clk, `freq_valid` pulses with `freq` = 10, `overflow` = 0, for at least 3 consecutive windows.
- Constant input: `sig_in` held low, then held high (including high through reset release) → `freq` = 0 on every window; no spurious count at reset release.
- Saturation: CNT_W = 4, `sig_in` period 4 clk → `freq` = 15, `overflow` = 1. Next window with `sig_in` period 10 → `freq` = 10, `overflow` = 0.
- Abort: `en` dropped at gate cycle 50 → `busy` falls next cycle; no `freq_valid`; `freq` keeps its prior value. `en` re-raised → a full 100-cycle window follows.
- Boundary edge: align an `edge` pulse to gate_cnt = 99 with otherwise period-20 input → that edge appears in exactly one window. The sum of counts over 5 windows equals the number of generated rising edges.
- Reset mid-window: assert `rst` at gate cycle 40 → all outputs at reset values within the same cycle. After release with `en` = 1, the first `freq_valid` arrives 101 cycles later.
